// File: rtl/byte_serial_add_ctrl.sv
// byte_serial_add_ctrl
//   Adds two 8*NBYTES-bit operands one byte per cycle through an external
//   8-bit adder. The byte operands and carry go out on add_a/add_b/add_cin,
//   and the adder answers combinationally on add_sum/add_cout.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request a new addition (accepted in IDLE or DONE)
//   a_in, b_in, cin    operands and carry-in, captured on acceptance
//   busy               high while an addition is in progress
//   done               one-cycle completion pulse
//   sum_out, cout_out  result and carry-out of the last completed addition
//   ovf_out            two's-complement overflow of the last completed addition
//   add_a, add_b       byte operands to the external adder (0 outside RUN)
//   add_cin            carry into the external adder (0 outside RUN)
//   add_sum, add_cout  external adder result
module byte_serial_add_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a_in,
    input  logic [8*NBYTES-1:0]   b_in,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum_out,
    output logic                  cout_out,
    output logic                  ovf_out,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [W-1:0]      a_sh;     // remaining (not yet presented) bytes of A
    logic [W-1:0]      b_sh;     // remaining (not yet presented) bytes of B
    logic [W-1:0]      work;     // partial sums, shifted in from the top
    logic              a_msb;    // sign bits of the captured operands
    logic              b_msb;
    logic              carry;
    logic [IDXW-1:0]   idx;
    logic              last_byte;
    logic [W-1:0]      work_next;

    assign last_byte = (idx == IDXW'(NBYTES - 1));
    // After NBYTES shifts byte 0 of the result lands in work[7:0].
    assign work_next = {add_sum, work[W-1:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            work     <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            carry    <= 1'b0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum_out  <= '0;
            cout_out <= 1'b0;
            ovf_out  <= 1'b0;
            add_a    <= '0;
            add_b    <= '0;
            add_cin  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Byte 0 is presented directly; the shifters hold the rest.
                        state   <= RUN;
                        busy    <= 1'b1;
                        a_sh    <= a_in >> 8;
                        b_sh    <= b_in >> 8;
                        add_a   <= a_in[7:0];
                        add_b   <= b_in[7:0];
                        add_cin <= cin;
                        carry   <= cin;
                        a_msb   <= a_in[W-1];
                        b_msb   <= b_in[W-1];
                        idx     <= '0;
                        work    <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work  <= work_next;
                    carry <= add_cout;
                    idx   <= idx + IDXW'(1);
                    if (last_byte) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum_out  <= work_next;
                        cout_out <= add_cout;
                        ovf_out  <= (a_msb == b_msb) && (add_sum[7] != a_msb);
                        add_a    <= '0;
                        add_b    <= '0;
                        add_cin  <= 1'b0;
                    end else begin
                        add_a   <= a_sh[7:0];
                        add_b   <= b_sh[7:0];
                        add_cin <= add_cout;
                        a_sh    <= a_sh >> 8;
                        b_sh    <= b_sh >> 8;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// tb_byte_serial_add_ctrl
//   Directed bench for byte_serial_add_ctrl (NBYTES=4) with a behavioural
//   external 8-bit adder and hand-computed expected results.
module tb_byte_serial_add_ctrl;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   a_in = '0;
    logic [31:0]   b_in = '0;
    logic          cin = 1'b0;
    logic          busy;
    logic          done;
    logic [31:0]   sum_out;
    logic          cout_out;
    logic          ovf_out;
    logic [7:0]    add_a;
    logic [7:0]    add_b;
    logic          add_cin;
    logic [7:0]    add_sum;
    logic          add_cout;
    logic [8:0]    add_res;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [3:0]    cin_trace;

    byte_serial_add_ctrl #(.NBYTES(NB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out),
        .ovf_out  (ovf_out),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // External 8-bit adder
    assign add_res  = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
    assign add_sum  = add_res[7:0];
    assign add_cout = add_res[8];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  busy,     1'b0);
        check({tag, "_done"},  done,     1'b0);
        check({tag, "_sum"},   sum_out,  32'h0);
        check({tag, "_cout"},  cout_out, 1'b0);
        check({tag, "_ovf"},   ovf_out,  1'b0);
        check({tag, "_adda"},  add_a,    8'h0);
        check({tag, "_addb"},  add_b,    8'h0);
        check({tag, "_addc"},  add_cin,  1'b0);
    endtask

    // Called at 1 time unit after a rising edge; accepts at the next edge (E0).
    task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic c);
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_e0"}, busy, 1'b1);
        check({tag, "_done_e0"}, done, 1'b0);
    endtask

    // Steps through edges E(from)..E(4) and checks the result on E(4).
    task automatic finish_op(input string tag, input int from, input logic [31:0] es,
                             input logic ec, input logic eo);
        for (int c = from; c <= NB; c++) begin
            cin_trace[c-1] = add_cin;
            @(posedge clk); #1;
            if (c < NB) begin
                check({tag, "_busy_run"}, busy, 1'b1);
                check({tag, "_done_run"}, done, 1'b0);
            end else begin
                check({tag, "_done"},  done,     1'b1);
                check({tag, "_busy"},  busy,     1'b0);
                check({tag, "_sum"},   sum_out,  es);
                check({tag, "_cout"},  cout_out, ec);
                check({tag, "_ovf"},   ovf_out,  eo);
                check({tag, "_adda0"}, add_a,    8'h0);
            end
        end
    endtask

    task automatic after_done(input string tag, input logic [31:0] es);
        @(posedge clk); #1;
        check({tag, "_done_clr"}, done,    1'b0);
        check({tag, "_idle"},     busy,    1'b0);
        check({tag, "_hold"},     sum_out, es);
    endtask

    initial begin
        // Reset state and release
        #3;
        check_idle_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_idle_outputs("post_rst");
        end

        // 0x0F + 0x0F
        start_op("t1", 32'h0000000F, 32'h0000000F, 1'b0);
        finish_op("t1", 1, 32'h0000001E, 1'b0, 1'b0);
        after_done("t1", 32'h0000001E);

        // Carry ripples through every byte
        start_op("t2", 32'hFFFFFFFF, 32'h00000001, 1'b0);
        finish_op("t2", 1, 32'h00000000, 1'b1, 1'b0);
        check("t2_cin_trace", cin_trace, 4'b1110);
        after_done("t2", 32'h00000000);

        // Positive overflow via carry-in
        start_op("t3", 32'h7FFFFFFF, 32'h00000000, 1'b1);
        finish_op("t3", 1, 32'h80000000, 1'b0, 1'b1);
        check("t3_cin_trace", cin_trace, 4'b1111);
        after_done("t3", 32'h80000000);

        // Start during RUN ignored; start during DONE goes straight back to RUN
        start_op("t4", 32'h12345678, 32'h11111111, 1'b0);
        @(posedge clk); #1;                         // E1
        a_in  = 32'hAAAAAAAA;
        b_in  = 32'h55555555;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;                         // E2, start seen in RUN
        start = 1'b0;
        check("t4_busy_e2", busy, 1'b1);
        finish_op("t4", 3, 32'h23456789, 1'b0, 1'b0);
        start_op("t5", 32'h80000000, 32'h80000000, 1'b0);
        finish_op("t5", 1, 32'h00000000, 1'b1, 1'b1);
        after_done("t5", 32'h00000000);

        // Mid-operation reset
        start_op("t6", 32'h01020304, 32'h10203040, 1'b0);
        @(posedge clk); #1;                         // E1, byte 0 written
        @(posedge clk); #1;                         // E2, byte 1 written
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("t6_no_done", done, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_idle", busy, 1'b0);
        start_op("t7", 32'h01020304, 32'h10203040, 1'b0);
        finish_op("t7", 1, 32'h11223344, 1'b0, 1'b0);
        after_done("t7", 32'h11223344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
